hit_resolver: RTL and testbench

//  Resolves the hitFlag side of the player interface. Takes both player instances' state and box

---
 rtl/hit_resolver.sv | 178 +++++++++++++++++
 tb/tb_hit_resolver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hit_resolver.sv
// Hit resolution between two players: box overlap on active attack frames, one-cycle
// hitFlag pulses, health bookkeeping with saturation, and the FIGHT/KO round state.
module hit_resolver #(
  parameter logic [7:0] HEALTH_MAX = 8'd100,
  parameter logic [7:0] DMG_BASIC  = 8'd10,
  parameter logic [7:0] DMG_DIR    = 8'd15,
  parameter logic [7:0] DMG_CHIP   = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       round_restart,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic [9:0] p1_bhb_x1, input logic [9:0] p1_bhb_x2, input logic [9:0] p1_bhb_y1, input logic [9:0] p1_bhb_y2,
  input  logic [9:0] p1_dhb_x1, input logic [9:0] p1_dhb_x2, input logic [9:0] p1_dhb_y1, input logic [9:0] p1_dhb_y2,
  input  logic [9:0] p1_mhb_x1, input logic [9:0] p1_mhb_x2, input logic [9:0] p1_mhb_y1, input logic [9:0] p1_mhb_y2,
  input  logic [9:0] p2_bhb_x1, input logic [9:0] p2_bhb_x2, input logic [9:0] p2_bhb_y1, input logic [9:0] p2_bhb_y2,
  input  logic [9:0] p2_dhb_x1, input logic [9:0] p2_dhb_x2, input logic [9:0] p2_dhb_y1, input logic [9:0] p2_dhb_y2,
  input  logic [9:0] p2_mhb_x1, input logic [9:0] p2_mhb_x2, input logic [9:0] p2_mhb_y1, input logic [9:0] p2_mhb_y2,
  output logic [1:0] p1_hitFlag,
  output logic [1:0] p2_hitFlag,
  output logic [7:0] p1_health,
  output logic [7:0] p2_health,
  output logic       ko,
  output logic [1:0] winner
);

  localparam logic [0:0] FIGHT = 1'b0;
  localparam logic [0:0] KO    = 1'b1;

  localparam logic [3:0] ST_BLOCK  = 4'd2;
  localparam logic [3:0] ST_B_END  = 4'd4;
  localparam logic [3:0] ST_D_END  = 4'd7;
  localparam logic [3:0] ST_HSTUN  = 4'd9;
  localparam logic [3:0] ST_BSTUN  = 4'd10;

  // Boxes are packed as {x1, x2, y1, y2}.
  function automatic logic box_overlap(input logic [39:0] a, input logic [39:0] b);
    return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
           (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
  endfunction

  function automatic logic is_active(input logic [3:0] st);
    return (st == ST_B_END) || (st == ST_D_END);
  endfunction

  function automatic logic strike(input logic [3:0] a_st, input logic [39:0] a_b, input logic [39:0] a_d,
                                  input logic [3:0] d_st, input logic [39:0] d_m,
                                  input logic [39:0] d_b, input logic [39:0] d_d);
    logic [39:0] act;
    logic        hurt;
    if (a_st == ST_B_END) begin
      act = a_b;
    end else begin
      act = a_d;
    end
    hurt = box_overlap(act, d_m) ||
           ((d_st >= 4'd3) && (d_st <= 4'd5) && box_overlap(act, d_b)) ||
           ((d_st >= 4'd6) && (d_st <= 4'd8) && box_overlap(act, d_d));
    return is_active(a_st) && hurt && (d_st != ST_HSTUN) && (d_st != ST_BSTUN);
  endfunction

  function automatic logic [7:0] damage(input logic [3:0] a_st, input logic [3:0] d_st);
    if (d_st == ST_BLOCK) begin
      return DMG_CHIP;
    end else if (a_st == ST_B_END) begin
      return DMG_BASIC;
    end else begin
      return DMG_DIR;
    end
  endfunction

  // Borrow out of the 9-bit difference means the hit would go below zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] h, input logic [7:0] d);
    logic [8:0] diff;
    diff = {1'b0, h} - {1'b0, d};
    if (diff[8]) begin
      return 8'd0;
    end else begin
      return diff[7:0];
    end
  endfunction

  logic [39:0] p1_bhb_s, p1_dhb_s, p1_mhb_s, p2_bhb_s, p2_dhb_s, p2_mhb_s;
  logic [0:0]  fsm_r;
  logic        p1_conn_r, p2_conn_r;
  logic [1:0]  p1_flag_r, p2_flag_r;
  logic [7:0]  p1_health_r, p2_health_r;
  logic        ko_r;
  logic [1:0]  winner_r;
  logic        p1_hit_s, p2_hit_s;
  logic [7:0]  p1_health_nx_s, p2_health_nx_s;

  assign p1_bhb_s = {p1_bhb_x1, p1_bhb_x2, p1_bhb_y1, p1_bhb_y2};
  assign p1_dhb_s = {p1_dhb_x1, p1_dhb_x2, p1_dhb_y1, p1_dhb_y2};
  assign p1_mhb_s = {p1_mhb_x1, p1_mhb_x2, p1_mhb_y1, p1_mhb_y2};
  assign p2_bhb_s = {p2_bhb_x1, p2_bhb_x2, p2_bhb_y1, p2_bhb_y2};
  assign p2_dhb_s = {p2_dhb_x1, p2_dhb_x2, p2_dhb_y1, p2_dhb_y2};
  assign p2_mhb_s = {p2_mhb_x1, p2_mhb_x2, p2_mhb_y1, p2_mhb_y2};

  // Hit detection (p1_hit_s: p1 lands on p2) and post-damage health.
  always_comb begin
    p1_hit_s = (fsm_r == FIGHT) && !p1_conn_r &&
               strike(p1_state, p1_bhb_s, p1_dhb_s, p2_state, p2_mhb_s, p2_bhb_s, p2_dhb_s);
    p2_hit_s = (fsm_r == FIGHT) && !p2_conn_r &&
               strike(p2_state, p2_bhb_s, p2_dhb_s, p1_state, p1_mhb_s, p1_bhb_s, p1_dhb_s);
    if (p2_hit_s) begin
      p1_health_nx_s = sat_sub(p1_health_r, damage(p2_state, p1_state));
    end else begin
      p1_health_nx_s = p1_health_r;
    end
    if (p1_hit_s) begin
      p2_health_nx_s = sat_sub(p2_health_r, damage(p1_state, p2_state));
    end else begin
      p2_health_nx_s = p2_health_r;
    end
  end

  // Round state, flag pulses, health and one-hit-per-window latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r       <= FIGHT;
      p1_conn_r   <= 1'b0;
      p2_conn_r   <= 1'b0;
      p1_flag_r   <= 2'b00;
      p2_flag_r   <= 2'b00;
      p1_health_r <= HEALTH_MAX;
      p2_health_r <= HEALTH_MAX;
      ko_r        <= 1'b0;
      winner_r    <= 2'b00;
    end else begin
      case (fsm_r)
        FIGHT: begin
          p2_flag_r   <= p1_hit_s ? ((p1_state == ST_B_END) ? 2'b01 : 2'b10) : 2'b00;
          p1_flag_r   <= p2_hit_s ? ((p2_state == ST_B_END) ? 2'b01 : 2'b10) : 2'b00;
          p1_health_r <= p1_health_nx_s;
          p2_health_r <= p2_health_nx_s;
          p1_conn_r   <= is_active(p1_state) && (p1_conn_r || p1_hit_s);
          p2_conn_r   <= is_active(p2_state) && (p2_conn_r || p2_hit_s);
          if ((p1_health_nx_s == 8'd0) || (p2_health_nx_s == 8'd0)) begin
            fsm_r    <= KO;
            ko_r     <= 1'b1;
            winner_r <= {p1_health_nx_s == 8'd0, p2_health_nx_s == 8'd0};
          end else begin
            fsm_r <= FIGHT;
          end
        end
        KO: begin
          p1_flag_r <= 2'b00;
          p2_flag_r <= 2'b00;
          if (round_restart) begin
            fsm_r       <= FIGHT;
            ko_r        <= 1'b0;
            winner_r    <= 2'b00;
            p1_health_r <= HEALTH_MAX;
            p2_health_r <= HEALTH_MAX;
            p1_conn_r   <= 1'b0;
            p2_conn_r   <= 1'b0;
          end else begin
            p1_conn_r <= is_active(p1_state) && p1_conn_r;
            p2_conn_r <= is_active(p2_state) && p2_conn_r;
          end
        end
        default: begin
          fsm_r <= FIGHT;
        end
      endcase
    end
  end

  assign p1_hitFlag = p1_flag_r;
  assign p2_hitFlag = p2_flag_r;
  assign p1_health  = p1_health_r;
  assign p2_health  = p2_health_r;
  assign ko         = ko_r;
  assign winner     = winner_r;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: single hits, window latching, blocking, invulnerability,
// trades, edge-touch overlap, saturation into KO, round restart and mid-round reset.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       rst, round_restart;
  logic [3:0] p1_state, p2_state;
  logic [9:0] p1_bhb_x1, p1_bhb_x2, p1_bhb_y1, p1_bhb_y2;
  logic [9:0] p1_dhb_x1, p1_dhb_x2, p1_dhb_y1, p1_dhb_y2;
  logic [9:0] p1_mhb_x1, p1_mhb_x2, p1_mhb_y1, p1_mhb_y2;
  logic [9:0] p2_bhb_x1, p2_bhb_x2, p2_bhb_y1, p2_bhb_y2;
  logic [9:0] p2_dhb_x1, p2_dhb_x2, p2_dhb_y1, p2_dhb_y2;
  logic [9:0] p2_mhb_x1, p2_mhb_x2, p2_mhb_y1, p2_mhb_y2;
  logic [1:0] p1_hitFlag, p2_hitFlag, winner;
  logic [7:0] p1_health, p2_health;
  logic       ko;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  hit_resolver dut (
    .clk(clk), .rst(rst), .round_restart(round_restart),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_bhb_x1(p1_bhb_x1), .p1_bhb_x2(p1_bhb_x2), .p1_bhb_y1(p1_bhb_y1), .p1_bhb_y2(p1_bhb_y2),
    .p1_dhb_x1(p1_dhb_x1), .p1_dhb_x2(p1_dhb_x2), .p1_dhb_y1(p1_dhb_y1), .p1_dhb_y2(p1_dhb_y2),
    .p1_mhb_x1(p1_mhb_x1), .p1_mhb_x2(p1_mhb_x2), .p1_mhb_y1(p1_mhb_y1), .p1_mhb_y2(p1_mhb_y2),
    .p2_bhb_x1(p2_bhb_x1), .p2_bhb_x2(p2_bhb_x2), .p2_bhb_y1(p2_bhb_y1), .p2_bhb_y2(p2_bhb_y2),
    .p2_dhb_x1(p2_dhb_x1), .p2_dhb_x2(p2_dhb_x2), .p2_dhb_y1(p2_dhb_y1), .p2_dhb_y2(p2_dhb_y2),
    .p2_mhb_x1(p2_mhb_x1), .p2_mhb_x2(p2_mhb_x2), .p2_mhb_y1(p2_mhb_y1), .p2_mhb_y2(p2_mhb_y2),
    .p1_hitFlag(p1_hitFlag), .p2_hitFlag(p2_hitFlag),
    .p1_health(p1_health), .p2_health(p2_health),
    .ko(ko), .winner(winner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All p1 boxes at x 0..10, all p2 boxes at x 500..510, everyone idle.
  task automatic park();
    p1_state = 4'd0; p2_state = 4'd0;
    p1_bhb_x1 = 10'd0;   p1_bhb_x2 = 10'd10;  p1_bhb_y1 = 10'd0; p1_bhb_y2 = 10'd10;
    p1_dhb_x1 = 10'd0;   p1_dhb_x2 = 10'd10;  p1_dhb_y1 = 10'd0; p1_dhb_y2 = 10'd10;
    p1_mhb_x1 = 10'd0;   p1_mhb_x2 = 10'd10;  p1_mhb_y1 = 10'd0; p1_mhb_y2 = 10'd10;
    p2_bhb_x1 = 10'd500; p2_bhb_x2 = 10'd510; p2_bhb_y1 = 10'd0; p2_bhb_y2 = 10'd10;
    p2_dhb_x1 = 10'd500; p2_dhb_x2 = 10'd510; p2_dhb_y1 = 10'd0; p2_dhb_y2 = 10'd10;
    p2_mhb_x1 = 10'd500; p2_mhb_x2 = 10'd510; p2_mhb_y1 = 10'd0; p2_mhb_y2 = 10'd10;
  endtask

  initial begin
    rst = 1'b1; round_restart = 1'b0;
    park();
    step(); step();
    chk("rst_p1_flag", 32'(p1_hitFlag), 32'd0);
    chk("rst_p2_flag", 32'(p2_hitFlag), 32'd0);
    chk("rst_p1_health", 32'(p1_health), 32'd100);
    chk("rst_p2_health", 32'(p2_health), 32'd100);
    chk("rst_ko", 32'(ko), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    rst = 1'b0;
    step();

    // Basic hit with edge-touching boxes (p1 bhb x2 = p2 mhb x1 = 200).
    p1_bhb_x1 = 10'd100; p1_bhb_x2 = 10'd200;
    p2_mhb_x1 = 10'd200; p2_mhb_x2 = 10'd300;
    p1_state = 4'd4;
    step();
    chk("basic_flag", 32'(p2_hitFlag), 32'd1);
    chk("basic_health", 32'(p2_health), 32'd90);
    chk("basic_attacker_flag", 32'(p1_hitFlag), 32'd0);
    step();
    chk("held_flag_drop", 32'(p2_hitFlag), 32'd0);
    chk("held_health", 32'(p2_health), 32'd90);
    step();
    chk("held_flag_2", 32'(p2_hitFlag), 32'd0);
    p1_state = 4'd0;
    step();
    p1_state = 4'd4;
    step();
    chk("reenter_flag", 32'(p2_hitFlag), 32'd1);
    chk("reenter_health", 32'(p2_health), 32'd80);
    p1_state = 4'd0;
    step();

    // One unit apart: no overlap.
    p2_mhb_x1 = 10'd201;
    p1_state = 4'd4;
    step();
    chk("gap_flag", 32'(p2_hitFlag), 32'd0);
    chk("gap_health", 32'(p2_health), 32'd80);
    p1_state = 4'd0; p2_mhb_x1 = 10'd200;
    step();

    // Directional hit against a blocker, then against hitstun, then unblocked.
    p1_dhb_x1 = 10'd100; p1_dhb_x2 = 10'd200;
    p2_state = 4'd2; p1_state = 4'd7;
    step();
    chk("chip_flag", 32'(p2_hitFlag), 32'd2);
    chk("chip_health", 32'(p2_health), 32'd78);
    p1_state = 4'd0;
    step();
    p2_state = 4'd9; p1_state = 4'd7;
    step();
    chk("invuln_flag", 32'(p2_hitFlag), 32'd0);
    chk("invuln_health", 32'(p2_health), 32'd78);
    p1_state = 4'd0; p2_state = 4'd0;
    step();
    p1_state = 4'd7;
    step();
    chk("dir_flag", 32'(p2_hitFlag), 32'd2);
    chk("dir_health", 32'(p2_health), 32'd63);
    p1_state = 4'd0;
    step();

    // Defender bhb is hurtable only in states 3-5.
    p2_mhb_x1 = 10'd600; p2_mhb_x2 = 10'd700;
    p2_bhb_x1 = 10'd150; p2_bhb_x2 = 10'd250;
    p2_state = 4'd3; p1_state = 4'd4;
    step();
    chk("ext_hurt_flag", 32'(p2_hitFlag), 32'd1);
    chk("ext_hurt_health", 32'(p2_health), 32'd53);
    p1_state = 4'd0; p2_state = 4'd0;
    step();
    p1_state = 4'd4;
    step();
    chk("no_ext_hurt_flag", 32'(p2_hitFlag), 32'd0);
    chk("no_ext_hurt_health", 32'(p2_health), 32'd53);
    p1_state = 4'd0;
    step();

    // Trade: every box on top of every other.
    p1_bhb_x1 = 10'd100; p1_bhb_x2 = 10'd200; p1_mhb_x1 = 10'd100; p1_mhb_x2 = 10'd200;
    p2_bhb_x1 = 10'd100; p2_bhb_x2 = 10'd200; p2_mhb_x1 = 10'd100; p2_mhb_x2 = 10'd200;
    p1_state = 4'd4; p2_state = 4'd4;
    step();
    chk("trade_p1_flag", 32'(p1_hitFlag), 32'd1);
    chk("trade_p2_flag", 32'(p2_hitFlag), 32'd1);
    chk("trade_p1_health", 32'(p1_health), 32'd90);
    chk("trade_p2_health", 32'(p2_health), 32'd43);
    p1_state = 4'd0; p2_state = 4'd0;
    round_restart = 1'b1;
    step();
    round_restart = 1'b0;
    chk("restart_in_fight_health", 32'(p2_health), 32'd43);
    chk("restart_in_fight_ko", 32'(ko), 32'd0);

    // Grind p2 down to 3, then a saturating hit ends the round.
    for (int i = 0; i < 4; i++) begin
      p1_state = 4'd4;
      step();
      chk("grind_health", 32'(p2_health), 32'(33 - 10 * i));
      p1_state = 4'd0;
      step();
    end
    p1_state = 4'd4;
    step();
    chk("ko_health", 32'(p2_health), 32'd0);
    chk("ko_flag", 32'(p2_hitFlag), 32'd1);
    chk("ko_ko", 32'(ko), 32'd1);
    chk("ko_winner", 32'(winner), 32'd1);
    p1_state = 4'd0;
    step();
    p1_state = 4'd4; p2_state = 4'd4;
    step();
    chk("ko_frozen_p2_flag", 32'(p2_hitFlag), 32'd0);
    chk("ko_frozen_p1_flag", 32'(p1_hitFlag), 32'd0);
    chk("ko_frozen_p1_health", 32'(p1_health), 32'd90);
    chk("ko_frozen_p2_health", 32'(p2_health), 32'd0);
    p1_state = 4'd0; p2_state = 4'd0;
    round_restart = 1'b1;
    step();
    round_restart = 1'b0;
    chk("restart_p1_health", 32'(p1_health), 32'd100);
    chk("restart_p2_health", 32'(p2_health), 32'd100);
    chk("restart_ko", 32'(ko), 32'd0);
    chk("restart_winner", 32'(winner), 32'd0);

    // Fight resumes, then an asynchronous reset drops the pending pulse.
    p1_state = 4'd4;
    step();
    chk("resume_flag", 32'(p2_hitFlag), 32'd1);
    chk("resume_health", 32'(p2_health), 32'd90);
    rst = 1'b1;
    #1;
    chk("midrst_flag", 32'(p2_hitFlag), 32'd0);
    chk("midrst_health", 32'(p2_health), 32'd100);
    step();
    rst = 1'b0;
    p1_state = 4'd0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
